// File: rtl/calc3_pkg.sv
// Shared types for the CALC-3 port master: command/response codes, tag
// width and the per-tag tracking state.
package calc3_pkg;

  localparam int TAG_W    = 2;
  localparam int NUM_TAGS = 4;

  typedef enum logic [3:0] {
    CMD_NOP   = 4'b0000,
    CMD_ADD   = 4'b0001,
    CMD_SUB   = 4'b0010,
    CMD_SHL   = 4'b0101,
    CMD_SHR   = 4'b0110,
    CMD_STORE = 4'b1001,
    CMD_FETCH = 4'b1010,
    CMD_BZ    = 4'b1100,
    CMD_BEQ   = 4'b1101
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_ERR  = 2'b10,
    RESP_R11  = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    TAG_IDLE    = 2'b00,
    TAG_WAIT    = 2'b01,
    TAG_EXPIRED = 2'b10
  } tag_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [TAG_W-1:0] lowest_set(input logic [NUM_TAGS-1:0] v);
    logic [TAG_W-1:0] idx;
    idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (v[i]) idx = TAG_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/calc3_tag_tracker.sv
// Lifecycle of one outstanding tag: remembers the issued command and
// times out the DUT with a terminal-count down-counter.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   TAG_IDLE    | free, may be allocated to a new command
//   TAG_WAIT    | issued, waiting for a DUT response, timer running
//   TAG_EXPIRED | timer ran out, waiting for the arbiter to report it
module calc3_tag_tracker
  import calc3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       issue,
  input  logic [3:0] issue_cmd,
  input  logic       rsp_hit,
  input  logic       report,
  output tag_state_e state,
  output logic [3:0] cmd
);

  // Counter holds the cycles left after the current one; terminal count 0
  // lands on the cycle where the elapsed count equals TIMEOUT_CYCLES.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  tag_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cmd_q, cmd_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TAG_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      TAG_IDLE: begin
        if (issue) begin
          state_d = TAG_WAIT;
          cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
          cmd_d   = issue_cmd;
        end
      end
      TAG_WAIT: begin
        // A response in the terminal cycle beats the expiry.
        if (rsp_hit)             state_d = TAG_IDLE;
        else if (cnt_q == '0)    state_d = TAG_EXPIRED;
        else                     cnt_d   = cnt_q - CNT_W'(1);
      end
      TAG_EXPIRED: begin
        if (rsp_hit || report) state_d = TAG_IDLE;
      end
      default: state_d = TAG_IDLE;
    endcase
  end

  assign state = state_q;
  assign cmd   = cmd_q;

endmodule

// File: rtl/calc3_port_master.sv
// Initiator for one CALC-3 request/response port: tag allocation, request
// issue, response matching and timeout reporting on a completion stream.
module calc3_port_master
  import calc3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cmd,
  input  logic [3:0]       in_d1,
  input  logic [3:0]       in_d2,
  input  logic [3:0]       in_r1,
  input  logic [31:0]      in_data,
  output logic [3:0]       req_cmd,
  output logic [3:0]       req_d1,
  output logic [3:0]       req_d2,
  output logic [3:0]       req_r1,
  output logic [31:0]      req_data,
  output logic [TAG_W-1:0] req_tag,
  input  logic [1:0]       out_resp,
  input  logic [31:0]      out_data,
  input  logic [TAG_W-1:0] out_tag,
  output logic             cpl_valid,
  output logic [TAG_W-1:0] cpl_tag,
  output logic [3:0]       cpl_cmd,
  output logic [1:0]       cpl_resp,
  output logic [31:0]      cpl_data,
  output logic             cpl_timeout,
  output logic [2:0]       outstanding,
  output logic             spurious_resp
);

  tag_state_e          tag_state [NUM_TAGS];
  logic [3:0]          tag_cmd   [NUM_TAGS];
  logic [NUM_TAGS-1:0] idle_vec, exp_vec, issue_vec, rsp_hit, report_vec;
  logic [TAG_W-1:0]    alloc_tag, rpt_tag;
  logic                accept, issue_en, rsp_valid;
  logic [2:0]          busy_cnt;

  always_comb begin
    idle_vec = '0;
    exp_vec  = '0;
    busy_cnt = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      idle_vec[i] = (tag_state[i] == TAG_IDLE);
      exp_vec[i]  = (tag_state[i] == TAG_EXPIRED);
      if (tag_state[i] != TAG_IDLE) busy_cnt = busy_cnt + 3'd1;
    end
  end

  assign in_ready    = |idle_vec;
  assign outstanding = busy_cnt;
  assign alloc_tag   = lowest_set(idle_vec);
  assign rpt_tag     = lowest_set(exp_vec);
  assign accept      = in_valid && in_ready;
  // NOP is consumed from the stream but never occupies a tag.
  assign issue_en    = accept && (in_cmd != CMD_NOP);
  assign rsp_valid   = (out_resp != RESP_NONE);

  always_comb begin
    issue_vec  = '0;
    rsp_hit    = '0;
    report_vec = '0;
    if (issue_en) issue_vec[alloc_tag] = 1'b1;
    if (rsp_valid)      rsp_hit[out_tag]    = 1'b1;
    else if (|exp_vec)  report_vec[rpt_tag] = 1'b1;
  end

  for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag
    calc3_tag_tracker #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tracker (
      .clk      (clk),
      .reset_n  (reset_n),
      .issue    (issue_vec[g]),
      .issue_cmd(in_cmd),
      .rsp_hit  (rsp_hit[g]),
      .report   (report_vec[g]),
      .state    (tag_state[g]),
      .cmd      (tag_cmd[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_cmd       <= '0;
      req_d1        <= '0;
      req_d2        <= '0;
      req_r1        <= '0;
      req_data      <= '0;
      req_tag       <= '0;
      cpl_valid     <= 1'b0;
      cpl_tag       <= '0;
      cpl_cmd       <= '0;
      cpl_resp      <= '0;
      cpl_data      <= '0;
      cpl_timeout   <= 1'b0;
      spurious_resp <= 1'b0;
    end else begin
      req_cmd  <= issue_en ? in_cmd    : 4'b0000;
      req_d1   <= issue_en ? in_d1     : '0;
      req_d2   <= issue_en ? in_d2     : '0;
      req_r1   <= issue_en ? in_r1     : '0;
      req_data <= issue_en ? in_data   : '0;
      req_tag  <= issue_en ? alloc_tag : '0;

      cpl_valid     <= 1'b0;
      cpl_tag       <= '0;
      cpl_cmd       <= '0;
      cpl_resp      <= RESP_NONE;
      cpl_data      <= '0;
      cpl_timeout   <= 1'b0;
      spurious_resp <= 1'b0;
      // DUT responses take the completion slot; expiries wait for a quiet cycle.
      if (rsp_valid) begin
        if (idle_vec[out_tag]) begin
          spurious_resp <= 1'b1;
        end else begin
          cpl_valid <= 1'b1;
          cpl_tag   <= out_tag;
          cpl_cmd   <= tag_cmd[out_tag];
          cpl_resp  <= out_resp;
          cpl_data  <= out_data;
        end
      end else if (|exp_vec) begin
        cpl_valid   <= 1'b1;
        cpl_tag     <= rpt_tag;
        cpl_cmd     <= tag_cmd[rpt_tag];
        cpl_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc3_port_master.sv
// Directed and random stimulus for calc3_port_master, checked against a
// cycle-count reference model of tag occupancy, deadlines and completions.
module tb_calc3_port_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cmd, in_d1, in_d2, in_r1;
  logic [31:0] in_data;
  logic [3:0]  req_cmd, req_d1, req_d2, req_r1;
  logic [31:0] req_data;
  logic [1:0]  req_tag;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        cpl_valid;
  logic [1:0]  cpl_tag;
  logic [3:0]  cpl_cmd;
  logic [1:0]  cpl_resp;
  logic [31:0] cpl_data;
  logic        cpl_timeout;
  logic [2:0]  outstanding;
  logic        spurious_resp;

  int checks   = 0;
  int failures = 0;

  // reference model: which tags hold a command, since when, and which command
  bit         m_busy [4];
  int         m_iss  [4];
  logic [3:0] m_cmd  [4];
  int         cyc = 0;

  logic [3:0]  e_req_cmd, e_req_d1, e_req_d2, e_req_r1;
  logic [31:0] e_req_data, e_cpl_data;
  logic [1:0]  e_req_tag, e_cpl_tag, e_cpl_resp;
  logic [3:0]  e_cpl_cmd;
  logic        e_cpl_valid, e_cpl_to, e_sp, e_rdy;
  logic [2:0]  e_out;

  always #5 clk = ~clk;

  calc3_port_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_d1(in_d1),
    .in_d2(in_d2), .in_r1(in_r1), .in_data(in_data),
    .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1),
    .req_data(req_data), .req_tag(req_tag),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_cmd(cpl_cmd), .cpl_resp(cpl_resp),
    .cpl_data(cpl_data), .cpl_timeout(cpl_timeout), .outstanding(outstanding),
    .spurious_resp(spurious_resp)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", name, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 1'b0;
      m_iss[i]  = 0;
      m_cmd[i]  = '0;
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_req_cmd"}, req_cmd, 0);
    check({name, "_req_data"}, req_data, 0);
    check({name, "_req_tag"}, req_tag, 0);
    check({name, "_cpl_valid"}, cpl_valid, 0);
    check({name, "_cpl_timeout"}, cpl_timeout, 0);
    check({name, "_spurious"}, spurious_resp, 0);
    check({name, "_outstanding"}, outstanding, 0);
    check({name, "_in_ready"}, in_ready, 1);
  endtask

  // One clock: drive inputs, predict the registered outputs, compare after the edge.
  task automatic step(input logic v, input logic [3:0] c, input logic [3:0] d1,
                      input logic [3:0] d2, input logic [3:0] r1, input logic [31:0] dat,
                      input logic [1:0] rs, input logic [1:0] rt, input logic [31:0] rd);
    int  alloc;
    bit  acc, iss, done;
    in_valid = v; in_cmd = c; in_d1 = d1; in_d2 = d2; in_r1 = r1; in_data = dat;
    out_resp = rs; out_tag = rt; out_data = rd;

    alloc = -1;
    for (int i = 0; i < 4; i++) if (!m_busy[i] && alloc < 0) alloc = i;
    acc = v && (alloc >= 0);
    iss = acc && (c != 4'd0);
    e_req_cmd  = iss ? c : 4'd0;
    e_req_d1   = iss ? d1 : 4'd0;
    e_req_d2   = iss ? d2 : 4'd0;
    e_req_r1   = iss ? r1 : 4'd0;
    e_req_data = iss ? dat : 32'd0;
    e_req_tag  = iss ? 2'(alloc) : 2'd0;
    e_cpl_valid = 0; e_cpl_tag = 0; e_cpl_cmd = 0; e_cpl_resp = 0;
    e_cpl_data = 0; e_cpl_to = 0; e_sp = 0;
    if (rs != 2'd0) begin
      if (m_busy[rt]) begin
        e_cpl_valid = 1; e_cpl_tag = rt; e_cpl_cmd = m_cmd[rt];
        e_cpl_resp = rs; e_cpl_data = rd;
        m_busy[rt] = 1'b0;
      end else begin
        e_sp = 1;
      end
    end else begin
      done = 1'b0;
      for (int i = 0; i < 4; i++) begin
        // a tag issued in cycle n has spent TO req/wait cycles by cycle n+TO
        if (!done && m_busy[i] && (cyc >= m_iss[i] + TO + 1)) begin
          e_cpl_valid = 1; e_cpl_tag = 2'(i); e_cpl_cmd = m_cmd[i]; e_cpl_to = 1;
          m_busy[i] = 1'b0;
          done = 1'b1;
        end
      end
    end
    if (iss) begin
      m_busy[alloc] = 1'b1;
      m_iss[alloc]  = cyc;
      m_cmd[alloc]  = c;
    end
    e_out = 0;
    for (int i = 0; i < 4; i++) if (m_busy[i]) e_out = e_out + 3'd1;
    e_rdy = (e_out != 3'd4);

    @(posedge clk);
    #1;
    cyc++;
    check("req_cmd", req_cmd, e_req_cmd);
    check("req_d1", req_d1, e_req_d1);
    check("req_d2", req_d2, e_req_d2);
    check("req_r1", req_r1, e_req_r1);
    check("req_data", req_data, e_req_data);
    check("req_tag", req_tag, e_req_tag);
    check("cpl_valid", cpl_valid, e_cpl_valid);
    check("cpl_tag", cpl_tag, e_cpl_tag);
    check("cpl_cmd", cpl_cmd, e_cpl_cmd);
    check("cpl_resp", cpl_resp, e_cpl_resp);
    check("cpl_data", cpl_data, e_cpl_data);
    check("cpl_timeout", cpl_timeout, e_cpl_to);
    check("spurious_resp", spurious_resp, e_sp);
    check("outstanding", outstanding, e_out);
    check("in_ready", in_ready, e_rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmd(input logic [3:0] c);
    step(1, c, 4'($urandom), 4'($urandom), 4'($urandom), $urandom, 0, 0, 0);
  endtask

  initial begin
    int seen_at;
    model_clear();
    reset_n = 1'b0;
    in_valid = 0; in_cmd = 0; in_d1 = 0; in_d2 = 0; in_r1 = 0; in_data = 0;
    out_resp = 0; out_tag = 0; out_data = 0;
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);

    // single ADD and its response
    step(1, 4'b0001, 4'd1, 4'd2, 4'd3, 32'h0, 0, 0, 0);
    check("add_req_cmd", req_cmd, 4'b0001);
    check("add_req_tag", req_tag, 0);
    check("add_req_d1", req_d1, 1);
    step(0, 0, 0, 0, 0, 0, 2'b01, 2'd0, 32'hCAFE_0001);
    check("add_cpl_valid", cpl_valid, 1);
    check("add_cpl_cmd", cpl_cmd, 4'b0001);
    check("add_cpl_resp", cpl_resp, 2'b01);
    check("add_outstanding", outstanding, 0);

    // fill all four tags, fifth command waits for tag 2 to free
    for (int i = 0; i < 4; i++) cmd(4'b0010);
    check("full_in_ready", in_ready, 0);
    check("full_outstanding", outstanding, 4);
    step(1, 4'b1001, 4'd5, 4'd6, 4'd7, 32'h1234_5678, 2'b10, 2'd2, 32'h55);
    check("full_cpl_tag", cpl_tag, 2);
    check("full_no_issue", req_cmd, 0);
    step(1, 4'b1001, 4'd5, 4'd6, 4'd7, 32'h1234_5678, 0, 0, 0);
    check("fifth_tag", req_tag, 2);
    check("fifth_cmd", req_cmd, 4'b1001);
    idle(16);

    // FETCH timeout then a late response is spurious
    cmd(4'b1010);
    seen_at = -1;
    for (int i = 0; i < 11; i++) begin
      idle(1);
      if (cpl_valid && cpl_timeout && seen_at < 0) seen_at = i;
    end
    check("fetch_timeout_cycle", 32'(seen_at), 8);
    step(0, 0, 0, 0, 0, 0, 2'b01, 2'd0, 32'h9);
    check("late_spurious", spurious_resp, 1);
    check("late_no_cpl", cpl_valid, 0);

    // tag 1 response in tag 0's expiry cycle
    cmd(4'b0101);
    cmd(4'b0110);
    idle(TO - 2);
    step(0, 0, 0, 0, 0, 0, 2'b01, 2'd1, 32'hAA);
    check("race_first_tag", cpl_tag, 1);
    check("race_first_to", cpl_timeout, 0);
    idle(1);
    check("race_second_tag", cpl_tag, 0);
    check("race_second_to", cpl_timeout, 1);
    idle(4);

    // NOP is swallowed
    cmd(4'b0000);
    check("nop_req_cmd", req_cmd, 0);
    check("nop_outstanding", outstanding, 0);
    cmd(4'b1100);
    check("after_nop_tag", req_tag, 0);
    step(0, 0, 0, 0, 0, 0, 2'b11, 2'd0, 32'h7);
    idle(1);

    // reset with three tags in flight
    for (int i = 0; i < 3; i++) cmd(4'b1101);
    reset_n = 1'b0;
    #2;
    check_all_zero("midreset");
    @(posedge clk); #1;
    check("midreset_cpl_hold", cpl_valid, 0);
    reset_n = 1'b1;
    model_clear();
    cmd(4'b0001);
    check("post_reset_tag", req_tag, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] rs;
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom),
           4'($urandom), 4'($urandom), $urandom, rs, 2'($urandom), $urandom);
    end
    idle(2 * TO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
